llc_snoop_sequencer: RTL and testbench

//  Sequences bus snoops (READ, WRITE, RDX, INVALIDATE) against the LLC tag/MESI array.
//  Per snoop it: arbitrates for the array (shared with the processor-side controller),

---
 rtl/llc_snoop_pkg.sv | 88 ++++++++
 rtl/llc_way_match.sv | 31 +++
 rtl/llc_snoop_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_llc_snoop_sequencer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_snoop_pkg.sv
// Shared types and width helpers for the LLC snoop path and the processor-side controller.
package llc_snoop_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_RDX   = 2'd2,
        OP_INVAL = 2'd3
    } snoop_op_t;

    typedef enum logic [1:0] {
        RES_NOHIT = 2'd0,
        RES_HIT   = 2'd1,
        RES_HITM  = 2'd2
    } snoop_res_t;

    typedef enum logic [1:0] {
        MSG_GETLINE        = 2'd0,
        MSG_INVALIDATELINE = 2'd1
    } l1_msg_t;

    // Everything a snoop has to do once its lookup result is known.
    typedef struct packed {
        snoop_res_t res;
        logic       getl;
        logic       invl;
        logic       wr;
        mesi_t      next_mesi;
    } snoop_plan_t;

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned index_w,
                                              input int unsigned offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int unsigned way_width(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Snoop response, L1 actions and MESI successor for one op against the hit way.
    // E/M under INVAL is a protocol error: report HIT and leave the line alone.
    function automatic snoop_plan_t snoop_plan(input snoop_op_t op,
                                               input logic      hit,
                                               input mesi_t     m);
        snoop_plan_t p;
        p.res       = RES_NOHIT;
        p.getl      = 1'b0;
        p.invl      = 1'b0;
        p.wr        = 1'b0;
        p.next_mesi = MESI_I;
        if (hit) begin
            case (op)
                OP_READ: begin
                    p.res       = (m == MESI_M) ? RES_HITM : RES_HIT;
                    p.getl      = (m == MESI_M);
                    p.wr        = (m != MESI_S);
                    p.next_mesi = MESI_S;
                end
                OP_RDX: begin
                    p.res       = (m == MESI_M) ? RES_HITM : RES_HIT;
                    p.getl      = (m == MESI_M);
                    p.invl      = 1'b1;
                    p.wr        = 1'b1;
                    p.next_mesi = MESI_I;
                end
                OP_INVAL: begin
                    p.res       = RES_HIT;
                    p.invl      = (m == MESI_S);
                    p.wr        = (m == MESI_S);
                    p.next_mesi = MESI_I;
                end
                default: begin
                    p.res = RES_NOHIT;
                end
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/llc_way_match.sv
// Combinational all-way tag compare; the lowest matching valid way wins.
module llc_way_match
    import llc_snoop_pkg::*;
#(
    parameter int unsigned WAYS  = 16,
    parameter int unsigned TAG_W = 12,
    parameter int unsigned WAY_W = 4
) (
    input  logic [WAYS*TAG_W-1:0] rd_tags,
    input  logic [WAYS*2-1:0]     rd_mesi,
    input  logic [TAG_W-1:0]      tag,
    output logic                  hit,
    output logic [WAY_W-1:0]      hit_way,
    output mesi_t                 hit_mesi
);

    // Scan from the top way down so the lowest-index match is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_mesi = MESI_I;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if ((rd_mesi[2*i +: 2] != 2'd0) && (rd_tags[i*TAG_W +: TAG_W] == tag)) begin
                hit      = 1'b1;
                hit_way  = WAY_W'(i);
                hit_mesi = mesi_t'(rd_mesi[2*i +: 2]);
            end
        end
    end

endmodule

// File: rtl/llc_snoop_sequencer.sv
// Sequences one bus snoop at a time: arbitrate, look up, respond, message L1, write MESI back.
module llc_snoop_sequencer
    import llc_snoop_pkg::*;
#(
    parameter  int unsigned ADDR_W   = 32,
    parameter  int unsigned OFFSET_W = 6,
    parameter  int unsigned INDEX_W  = 14,
    parameter  int unsigned WAYS     = 16,
    localparam int unsigned TAG_W    = tag_width(ADDR_W, INDEX_W, OFFSET_W),
    localparam int unsigned WAY_W    = way_width(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  snp_valid,
    output logic                  snp_ready,
    input  logic [1:0]            snp_op,
    input  logic [ADDR_W-1:0]     snp_addr,
    output logic                  arr_req,
    input  logic                  arr_gnt,
    output logic                  tag_rd_en,
    output logic [INDEX_W-1:0]    tag_idx,
    input  logic [WAYS*TAG_W-1:0] rd_tags,
    input  logic [WAYS*2-1:0]     rd_mesi,
    output logic                  tag_wr_en,
    output logic [WAY_W-1:0]      tag_wr_way,
    output logic [1:0]            tag_wr_mesi,
    output logic                  snp_res_vld,
    output logic [1:0]            snp_res,
    output logic                  l1_msg_vld,
    output logic [1:0]            l1_msg,
    output logic [ADDR_W-1:0]     l1_msg_addr,
    input  logic                  l1_msg_ack
);

    localparam int unsigned LINE_W = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_LOOKUP = 3'd2,
        S_EVAL   = 3'd3,
        S_GETL   = 3'd4,
        S_INVL   = 3'd5,
        S_WB     = 3'd6
    } state_t;

    state_t            state;
    snoop_op_t         req_op;
    logic [LINE_W-1:0] req_line;
    logic              invl_q;
    logic              wr_q;
    mesi_t             wr_mesi_q;
    logic [WAY_W-1:0]  wr_way_q;

    logic              m_hit;
    logic [WAY_W-1:0]  m_way;
    mesi_t             m_mesi;
    snoop_plan_t       plan_c;
    logic              unused_offset;

    // The line offset never matters to a snoop.
    assign unused_offset = ^snp_addr[OFFSET_W-1:0];

    llc_way_match #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .WAY_W (WAY_W)
    ) u_way_match (
        .rd_tags  (rd_tags),
        .rd_mesi  (rd_mesi),
        .tag      (req_line[LINE_W-1:INDEX_W]),
        .hit      (m_hit),
        .hit_way  (m_way),
        .hit_mesi (m_mesi)
    );

    // Decide the snoop outcome from the array data returned during EVAL.
    always_comb begin
        plan_c = snoop_plan(req_op, m_hit, m_mesi);
    end

    // Array data only lands in EVAL, so the response value rides on the registered strobe.
    assign snp_res = snp_res_vld ? plan_c.res : RES_NOHIT;

    // Snoop FSM with registered outputs; sync reset abandons any snoop in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            snp_ready   <= 1'b1;
            arr_req     <= 1'b0;
            tag_rd_en   <= 1'b0;
            tag_idx     <= '0;
            tag_wr_en   <= 1'b0;
            tag_wr_way  <= '0;
            tag_wr_mesi <= 2'd0;
            snp_res_vld <= 1'b0;
            l1_msg_vld  <= 1'b0;
            l1_msg      <= 2'd0;
            l1_msg_addr <= '0;
            req_op      <= OP_READ;
            req_line    <= '0;
            invl_q      <= 1'b0;
            wr_q        <= 1'b0;
            wr_mesi_q   <= MESI_I;
            wr_way_q    <= '0;
        end else begin
            tag_rd_en   <= 1'b0;
            tag_wr_en   <= 1'b0;
            snp_res_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (snp_valid) begin
                        req_op    <= snoop_op_t'(snp_op);
                        req_line  <= snp_addr[ADDR_W-1:OFFSET_W];
                        snp_ready <= 1'b0;
                        arr_req   <= 1'b1;
                        state     <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (arr_gnt) begin
                        tag_rd_en <= 1'b1;
                        tag_idx   <= req_line[INDEX_W-1:0];
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    snp_res_vld <= 1'b1;
                    state       <= S_EVAL;
                end
                S_EVAL: begin
                    invl_q    <= plan_c.invl;
                    wr_q      <= plan_c.wr;
                    wr_mesi_q <= plan_c.next_mesi;
                    wr_way_q  <= m_way;
                    if (plan_c.getl) begin
                        l1_msg_vld  <= 1'b1;
                        l1_msg      <= MSG_GETLINE;
                        l1_msg_addr <= {req_line, OFFSET_W'(0)};
                        state       <= S_GETL;
                    end else if (plan_c.invl) begin
                        l1_msg_vld  <= 1'b1;
                        l1_msg      <= MSG_INVALIDATELINE;
                        l1_msg_addr <= {req_line, OFFSET_W'(0)};
                        state       <= S_INVL;
                    end else if (plan_c.wr) begin
                        tag_wr_en   <= 1'b1;
                        tag_wr_way  <= m_way;
                        tag_wr_mesi <= plan_c.next_mesi;
                        state       <= S_WB;
                    end else begin
                        arr_req   <= 1'b0;
                        snp_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_GETL: begin
                    if (l1_msg_ack) begin
                        if (invl_q) begin
                            l1_msg <= MSG_INVALIDATELINE;
                            state  <= S_INVL;
                        end else if (wr_q) begin
                            l1_msg_vld  <= 1'b0;
                            tag_wr_en   <= 1'b1;
                            tag_wr_way  <= wr_way_q;
                            tag_wr_mesi <= wr_mesi_q;
                            state       <= S_WB;
                        end else begin
                            l1_msg_vld <= 1'b0;
                            arr_req    <= 1'b0;
                            snp_ready  <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                end
                S_INVL: begin
                    if (l1_msg_ack) begin
                        l1_msg_vld <= 1'b0;
                        if (wr_q) begin
                            tag_wr_en   <= 1'b1;
                            tag_wr_way  <= wr_way_q;
                            tag_wr_mesi <= wr_mesi_q;
                            state       <= S_WB;
                        end else begin
                            arr_req   <= 1'b0;
                            snp_ready <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_WB: begin
                    arr_req   <= 1'b0;
                    snp_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    arr_req   <= 1'b0;
                    snp_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llc_snoop_sequencer.sv
// Self-checking bench for llc_snoop_sequencer: directed scenarios plus randomized snoops.
module tb_llc_snoop_sequencer;
    import llc_snoop_pkg::*;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned OFFSET_W = 6;
    localparam int unsigned INDEX_W  = 14;
    localparam int unsigned WAYS     = 16;
    localparam int unsigned TAG_W    = 12;
    localparam int unsigned WAY_W    = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  snp_valid;
    logic                  snp_ready;
    logic [1:0]            snp_op;
    logic [ADDR_W-1:0]     snp_addr;
    logic                  arr_req;
    logic                  arr_gnt;
    logic                  tag_rd_en;
    logic [INDEX_W-1:0]    tag_idx;
    logic [WAYS*TAG_W-1:0] rd_tags;
    logic [WAYS*2-1:0]     rd_mesi;
    logic                  tag_wr_en;
    logic [WAY_W-1:0]      tag_wr_way;
    logic [1:0]            tag_wr_mesi;
    logic                  snp_res_vld;
    logic [1:0]            snp_res;
    logic                  l1_msg_vld;
    logic [1:0]            l1_msg;
    logic [ADDR_W-1:0]     l1_msg_addr;
    logic                  l1_msg_ack;

    int checks   = 0;
    int failures = 0;

    // Contents of the one set being snooped.
    logic [TAG_W-1:0] arr_tags [WAYS];
    logic [1:0]       arr_mesi [WAYS];

    // Observations gathered by run_snoop.
    int          o_rd_cnt, o_rd_cycle, o_rd_early, o_res_cnt, o_res_cycle;
    int          o_wr_cnt, o_done, o_unstable, o_arr_low, o_timeout, o_ready_at_accept;
    logic [13:0] o_rd_idx;
    logic [1:0]  o_res;
    logic [3:0]  o_wr_way;
    logic [1:0]  o_wr_mesi;
    logic [1:0]  q_msg  [$];
    logic [31:0] q_addr [$];

    logic [60:0] outs_wo_ready;
    assign outs_wo_ready = {arr_req, tag_rd_en, tag_idx, tag_wr_en, tag_wr_way, tag_wr_mesi,
                            snp_res_vld, snp_res, l1_msg_vld, l1_msg, l1_msg_addr};

    always #5 clk = ~clk;

    always_comb begin
        rd_tags = '0;
        rd_mesi = '0;
        for (int i = 0; i < int'(WAYS); i++) begin
            rd_tags[i*TAG_W +: TAG_W] = arr_tags[i];
            rd_mesi[2*i +: 2]         = arr_mesi[i];
        end
    end

    llc_snoop_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .snp_valid   (snp_valid),
        .snp_ready   (snp_ready),
        .snp_op      (snp_op),
        .snp_addr    (snp_addr),
        .arr_req     (arr_req),
        .arr_gnt     (arr_gnt),
        .tag_rd_en   (tag_rd_en),
        .tag_idx     (tag_idx),
        .rd_tags     (rd_tags),
        .rd_mesi     (rd_mesi),
        .tag_wr_en   (tag_wr_en),
        .tag_wr_way  (tag_wr_way),
        .tag_wr_mesi (tag_wr_mesi),
        .snp_res_vld (snp_res_vld),
        .snp_res     (snp_res),
        .l1_msg_vld  (l1_msg_vld),
        .l1_msg      (l1_msg),
        .l1_msg_addr (l1_msg_addr),
        .l1_msg_ack  (l1_msg_ack)
    );

    task automatic clear_set();
        for (int i = 0; i < int'(WAYS); i++) begin
            arr_tags[i] = TAG_W'($urandom);
            arr_mesi[i] = 2'd0;
        end
    endtask

    // One snoop from accept to ready; cycle c counts edges after the accept cycle (c=0).
    task automatic run_snoop(input logic [1:0] op, input logic [31:0] addr,
                             input int gnt_delay, input int ack_delay);
        int          held;
        logic        gnt_seen;
        logic [1:0]  pm;
        logic [31:0] pa;
        held = 0; gnt_seen = 1'b0; pm = 2'd0; pa = 32'd0;
        o_rd_cnt = 0; o_rd_cycle = -1; o_rd_early = 0; o_res_cnt = 0; o_res_cycle = -1;
        o_wr_cnt = 0; o_done = -1; o_unstable = 0; o_arr_low = 0; o_timeout = 0;
        o_rd_idx = '0; o_res = 2'd3; o_wr_way = '0; o_wr_mesi = 2'd0;
        q_msg.delete(); q_addr.delete();
        o_ready_at_accept = int'(snp_ready);
        snp_valid = 1'b1; snp_op = op; snp_addr = addr; arr_gnt = 1'b0; l1_msg_ack = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            gnt_seen = gnt_seen | arr_gnt;
            if (tag_rd_en) begin
                o_rd_cnt++; o_rd_cycle = c; o_rd_idx = tag_idx;
                if (!gnt_seen) o_rd_early++;
            end
            if (snp_res_vld) begin
                o_res_cnt++; o_res_cycle = c; o_res = snp_res;
            end
            if (tag_wr_en) begin
                o_wr_cnt++; o_wr_way = tag_wr_way; o_wr_mesi = tag_wr_mesi;
            end
            if (l1_msg_vld) begin
                if (held > 0 && (l1_msg !== pm || l1_msg_addr !== pa)) o_unstable++;
                pm = l1_msg; pa = l1_msg_addr;
                if (held >= ack_delay) begin
                    l1_msg_ack = 1'b1; q_msg.push_back(l1_msg); q_addr.push_back(l1_msg_addr);
                    held = 0;
                end else begin
                    l1_msg_ack = 1'b0; held++;
                end
            end else begin
                l1_msg_ack = 1'b0; held = 0;
            end
            if (snp_ready) begin
                o_done = c; snp_valid = 1'b0; arr_gnt = 1'b0;
                break;
            end
            if (!arr_req) o_arr_low++;
            arr_gnt   = (c >= 1 + gnt_delay);
            snp_valid = 1'($urandom);
            snp_op    = 2'($urandom);
            snp_addr  = $urandom;
        end
        if (o_done < 0) o_timeout = 1;
        l1_msg_ack = 1'b0;
    endtask

    // Expected behaviour from the MESI rules: new state per op, write only on change.
    task automatic model(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                         output logic [1:0] res, output logic getl, output logic invl,
                         output logic wr, output logic [3:0] way, output logic [1:0] nm);
        logic       hit;
        logic [1:0] m;
        hit = 1'b0; m = 2'd0; way = '0;
        for (int i = 0; i < int'(WAYS); i++) begin
            if (!hit && arr_mesi[i] != 2'd0 && arr_tags[i] == tag) begin
                hit = 1'b1; way = 4'(i); m = arr_mesi[i];
            end
        end
        res = 2'd0; getl = 1'b0; invl = 1'b0; wr = 1'b0; nm = m;
        if (hit && op != 2'd1) begin
            res  = (m == 2'd3 && op != 2'd3) ? 2'd2 : 2'd1;
            getl = (m == 2'd3) && (op != 2'd3);
            invl = (op == 2'd2) || (op == 2'd3 && m == 2'd1);
            if (op == 2'd0) nm = 2'd1;
            else if (op == 2'd2) nm = 2'd0;
            else if (m == 2'd1) nm = 2'd0;
            wr = (nm != m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; snp_valid = 1'b0; snp_op = 2'd0; snp_addr = '0;
        arr_gnt = 1'b0; l1_msg_ack = 1'b0;
        clear_set();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs_wo_ready !== 61'd0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0", outs_wo_ready);
        end
        checks++;
        if (snp_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b want=1", snp_ready);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (snp_ready !== 1'b1 || arr_req !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset ready=%b arr_req=%b want 1/0", snp_ready, arr_req);
        end
    endtask

    task automatic test_read_nohit();
        logic [31:0] a;
        a = {12'h123, 14'd5, 6'h15};
        clear_set();
        arr_tags[4] = 12'h122; arr_mesi[4] = 2'd3;
        arr_tags[6] = 12'h123; arr_mesi[6] = 2'd0;
        run_snoop(2'd0, a, 0, 0);
        checks++;
        if (o_ready_at_accept !== 1 || o_timeout !== 0) begin
            failures++; $display("FAIL nohit_handshake ready_at_accept=%0d timeout=%0d", o_ready_at_accept, o_timeout);
        end
        checks++;
        if (o_rd_cycle !== 2 || o_rd_cnt !== 1 || o_rd_idx !== 14'd5) begin
            failures++; $display("FAIL nohit_lookup cycle=%0d cnt=%0d idx=%0d want 2/1/5", o_rd_cycle, o_rd_cnt, o_rd_idx);
        end
        checks++;
        if (o_res_cycle !== 3 || o_res_cnt !== 1 || o_res !== 2'd0) begin
            failures++; $display("FAIL nohit_result cycle=%0d cnt=%0d res=%0d want 3/1/0", o_res_cycle, o_res_cnt, o_res);
        end
        checks++;
        if (o_done !== 4 || o_wr_cnt !== 0 || q_msg.size() !== 0) begin
            failures++; $display("FAIL nohit_tail done=%0d wr=%0d msgs=%0d want 4/0/0", o_done, o_wr_cnt, q_msg.size());
        end
    endtask

    task automatic test_rdx_m();
        logic [31:0] a;
        a = {12'hABC, 14'h1F0, 6'h2A};
        clear_set();
        arr_tags[3] = 12'hABC; arr_mesi[3] = 2'd3;
        run_snoop(2'd2, a, 0, 2);
        checks++;
        if (o_res !== 2'd2) begin
            failures++; $display("FAIL rdx_m_result got=%0d want=2", o_res);
        end
        checks++;
        if (q_msg.size() !== 2 || o_unstable !== 0) begin
            failures++; $display("FAIL rdx_m_msg_count got=%0d unstable=%0d want 2/0", q_msg.size(), o_unstable);
        end else begin
            checks++;
            if (q_msg[0] !== 2'd0 || q_msg[1] !== 2'd1 || q_addr[0] !== {a[31:6], 6'd0} || q_addr[1] !== {a[31:6], 6'd0}) begin
                failures++; $display("FAIL rdx_m_msgs got=%0d,%0d addr=%h want 0,1 addr=%h", q_msg[0], q_msg[1], q_addr[0], {a[31:6], 6'd0});
            end
        end
        checks++;
        if (o_wr_cnt !== 1 || o_wr_way !== 4'd3 || o_wr_mesi !== 2'd0 || o_done !== 11) begin
            failures++; $display("FAIL rdx_m_wb cnt=%0d way=%0d mesi=%0d done=%0d want 1/3/0/11", o_wr_cnt, o_wr_way, o_wr_mesi, o_done);
        end
    endtask

    task automatic test_read_e();
        logic [31:0] a;
        a = {12'h07E, 14'h2222, 6'h00};
        clear_set();
        arr_tags[7] = 12'h07E; arr_mesi[7] = 2'd2;
        run_snoop(2'd0, a, 0, 0);
        checks++;
        if (o_res !== 2'd1 || q_msg.size() !== 0) begin
            failures++; $display("FAIL read_e_result res=%0d msgs=%0d want 1/0", o_res, q_msg.size());
        end
        checks++;
        if (o_wr_cnt !== 1 || o_wr_way !== 4'd7 || o_wr_mesi !== 2'd1) begin
            failures++; $display("FAIL read_e_wb cnt=%0d way=%0d mesi=%0d want 1/7/1", o_wr_cnt, o_wr_way, o_wr_mesi);
        end
    endtask

    task automatic test_rdx_multi();
        logic [31:0] a;
        a = {12'h555, 14'h0042, 6'h3F};
        clear_set();
        arr_tags[2] = 12'h555; arr_mesi[2] = 2'd1;
        arr_tags[9] = 12'h555; arr_mesi[9] = 2'd1;
        run_snoop(2'd2, a, 0, 1);
        checks++;
        if (o_res !== 2'd1 || q_msg.size() !== 1) begin
            failures++; $display("FAIL rdx_multi_result res=%0d msgs=%0d want 1/1", o_res, q_msg.size());
        end else begin
            checks++;
            if (q_msg[0] !== 2'd1) begin
                failures++; $display("FAIL rdx_multi_msg got=%0d want=1", q_msg[0]);
            end
        end
        checks++;
        if (o_wr_cnt !== 1 || o_wr_way !== 4'd2 || o_wr_mesi !== 2'd0) begin
            failures++; $display("FAIL rdx_multi_wb cnt=%0d way=%0d mesi=%0d want 1/2/0", o_wr_cnt, o_wr_way, o_wr_mesi);
        end
    endtask

    task automatic test_grant_wait();
        logic [31:0] a;
        a = {12'h321, 14'd77, 6'h01};
        clear_set();
        run_snoop(2'd0, a, 10, 0);
        checks++;
        if (o_rd_early !== 0 || o_rd_cycle !== 12) begin
            failures++; $display("FAIL grant_wait_lookup early=%0d cycle=%0d want 0/12", o_rd_early, o_rd_cycle);
        end
        checks++;
        if (o_done !== 14 || o_arr_low !== 0) begin
            failures++; $display("FAIL grant_wait_ready done=%0d arr_low=%0d want 14/0", o_done, o_arr_low);
        end
    endtask

    task automatic test_reset_in_getl();
        logic [31:0] a;
        int          found;
        int          wr_seen;
        int          res_seen;
        a = {12'h0F0, 14'd9, 6'h00};
        clear_set();
        arr_tags[0] = 12'h0F0; arr_mesi[0] = 2'd3;
        found = 0; wr_seen = 0; res_seen = 0;
        snp_valid = 1'b1; snp_op = 2'd2; snp_addr = a; arr_gnt = 1'b1; l1_msg_ack = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            snp_valid = 1'b0;
            if (tag_wr_en) wr_seen++;
            if (l1_msg_vld && l1_msg == 2'd0) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found !== 1) begin
            failures++; $display("FAIL reset_getl_reach found=%0d want=1", found);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (outs_wo_ready !== 61'd0 || snp_ready !== 1'b1) begin
            failures++; $display("FAIL reset_getl_outputs got=%h ready=%b want 0/1", outs_wo_ready, snp_ready);
        end
        l1_msg_ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (tag_wr_en) wr_seen++;
            if (snp_res_vld) res_seen++;
        end
        l1_msg_ack = 1'b0;
        checks++;
        if (wr_seen !== 0 || res_seen !== 0 || snp_ready !== 1'b1) begin
            failures++; $display("FAIL reset_getl_aftermath wr=%0d res=%0d ready=%b want 0/0/1", wr_seen, res_seen, snp_ready);
        end
    endtask

    // Back-to-back randomized snoops: each starts in the cycle the previous one returns ready.
    task automatic test_random();
        logic [1:0]       op, e_res, e_mesi;
        logic [TAG_W-1:0] tag;
        logic [31:0]      a;
        logic             e_getl, e_invl, e_wr;
        logic [3:0]       e_way;
        logic [1:0]       e_msg [$];
        int               gd, ad, n;
        for (int it = 0; it < 40; it++) begin
            op  = 2'($urandom);
            tag = TAG_W'($urandom);
            a   = {tag, 14'($urandom), 6'($urandom)};
            gd  = $urandom_range(0, 3);
            ad  = $urandom_range(0, 3);
            clear_set();
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                int w;
                w = $urandom_range(0, int'(WAYS) - 1);
                arr_tags[w] = ($urandom_range(0, 3) == 0) ? (tag ^ 12'h001) : tag;
                arr_mesi[w] = 2'($urandom);
            end
            model(op, tag, e_res, e_getl, e_invl, e_wr, e_way, e_mesi);
            e_msg.delete();
            if (e_getl) e_msg.push_back(2'd0);
            if (e_invl) e_msg.push_back(2'd1);
            run_snoop(op, a, gd, ad);
            checks++;
            if (o_res !== e_res || o_res_cycle !== 3 + gd || o_res_cnt !== 1) begin
                failures++; $display("FAIL rand_result it=%0d op=%0d res=%0d cyc=%0d want res=%0d cyc=%0d", it, op, o_res, o_res_cycle, e_res, 3 + gd);
            end
            checks++;
            if (o_rd_idx !== a[19:6] || o_rd_cnt !== 1) begin
                failures++; $display("FAIL rand_index it=%0d idx=%h cnt=%0d want idx=%h cnt=1", it, o_rd_idx, o_rd_cnt, a[19:6]);
            end
            checks++;
            if (q_msg.size() !== e_msg.size() || o_unstable !== 0) begin
                failures++; $display("FAIL rand_msg_count it=%0d op=%0d got=%0d want=%0d unstable=%0d", it, op, q_msg.size(), e_msg.size(), o_unstable);
            end else begin
                for (int k = 0; k < e_msg.size(); k++) begin
                    checks++;
                    if (q_msg[k] !== e_msg[k] || q_addr[k] !== {a[31:6], 6'd0}) begin
                        failures++; $display("FAIL rand_msg it=%0d k=%0d got=%0d/%h want=%0d/%h", it, k, q_msg[k], q_addr[k], e_msg[k], {a[31:6], 6'd0});
                    end
                end
            end
            checks++;
            if (o_wr_cnt !== int'(e_wr) || (e_wr && (o_wr_way !== e_way || o_wr_mesi !== e_mesi))) begin
                failures++; $display("FAIL rand_wb it=%0d op=%0d cnt=%0d way=%0d mesi=%0d want cnt=%0d way=%0d mesi=%0d", it, op, o_wr_cnt, o_wr_way, o_wr_mesi, e_wr, e_way, e_mesi);
            end
            checks++;
            if (o_done !== 4 + gd + e_msg.size() * (ad + 1) + int'(e_wr) || o_arr_low !== 0 || o_rd_early !== 0) begin
                failures++; $display("FAIL rand_timing it=%0d done=%0d arr_low=%0d early=%0d want done=%0d", it, o_done, o_arr_low, o_rd_early, 4 + gd + e_msg.size() * (ad + 1) + int'(e_wr));
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_nohit();
        test_rdx_m();
        test_read_e();
        test_rdx_multi();
        test_grant_wait();
        test_reset_in_getl();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
